// File: rtl/pc_sequencer_if.sv
// Decoder/LUT-facing bundle of the PC sequencer: control strobes, LUT index and
// target, and the fetch address and status outputs.
interface pc_sequencer_if #(parameter int D = 10);
  logic         start;
  logic         stall;
  logic         halt_in;
  logic         branch_en;
  logic         call_en;
  logic         ret_en;
  logic [3:0]   branch_idx;
  logic [3:0]   lut_addr;
  logic [D-1:0] lut_target;
  logic [D-1:0] prog_ctr;
  logic         running;
  logic         done;
  logic         stack_err;

  modport master (
    output start, stall, halt_in, branch_en, call_en, ret_en, branch_idx, lut_target,
    input  lut_addr, prog_ctr, running, done, stack_err
  );

  modport slave (
    input  start, stall, halt_in, branch_en, call_en, ret_en, branch_idx, lut_target,
    output lut_addr, prog_ctr, running, done, stack_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, LUT branch, call/return through a small
// return-address stack, stall and halt, with a sticky stack error flag.
module pc_sequencer #(
  parameter int D     = 10,
  parameter int DEPTH = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  pc_sequencer_if.slave  bus
);

  localparam int SPW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           push;
  logic [D-1:0]   pc_inc;
  logic [SPW-2:0] top_idx;
  logic           stack_empty, stack_full;
  logic [D-1:0]   stack_q [DEPTH];

  assign pc_inc      = pc_q + D'(1);
  // With SP==DEPTH the low bits are zero, so this still wraps to DEPTH-1.
  assign top_idx     = sp_q[SPW-2:0] - (SPW-1)'(1);
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SPW'(DEPTH));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = '0;
          sp_d    = '0;
        end
      end
      S_RUN: begin
        if (bus.stall) begin
          state_d = S_RUN;
        end else if (bus.halt_in) begin
          state_d = S_HALT;
        end else if (bus.ret_en) begin
          if (stack_empty) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            pc_d = stack_q[top_idx];
            sp_d = sp_q - SPW'(1);
          end
        end else if (bus.call_en) begin
          if (stack_full) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = bus.lut_target;
            sp_d = sp_q + SPW'(1);
          end
        end else if (bus.branch_en) begin
          pc_d = bus.lut_target;
        end else begin
          pc_d = pc_inc;
        end
      end
      S_HALT: begin
        if (bus.start) begin
          state_d = S_RUN;
          pc_d    = '0;
          sp_d    = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // NOTE: stack storage is not reset; SP==0 after reset makes its contents unreachable.
  always_ff @(posedge Clk) begin
    if (push) stack_q[sp_q[SPW-2:0]] <= pc_inc;
  end

  assign bus.lut_addr  = bus.branch_idx;
  assign bus.prog_ctr  = pc_q;
  assign bus.running   = (state_q == S_RUN);
  assign bus.done      = (state_q == S_HALT);
  assign bus.stack_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// against a queue-based model of the sequencing rules.
module tb_pc_sequencer;

  localparam int D     = 10;
  localparam int DEPTH = 4;

  logic Clk;
  logic Reset_n;
  int   n_tests;
  int   n_fail;

  pc_sequencer_if #(.D(D)) bus ();

  pc_sequencer #(.D(D), .DEPTH(DEPTH)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  logic [D-1:0] lut [16];
  assign bus.lut_target = lut[bus.lut_addr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: a running/halted pair, an integer PC and a queue as the stack.
  bit m_run, m_halt, m_err;
  int m_pc;
  int m_stack[$];

  function automatic void model_reset();
    m_run  = 1'b0;
    m_halt = 1'b0;
    m_err  = 1'b0;
    m_pc   = 0;
    m_stack.delete();
  endfunction

  function automatic void model_step();
    if (!m_run && !m_halt) begin
      if (bus.start) begin m_run = 1'b1; m_pc = 0; end
    end else if (m_halt) begin
      if (bus.start) begin
        m_halt = 1'b0; m_run = 1'b1; m_pc = 0; m_err = 1'b0; m_stack.delete();
      end
    end else if (bus.stall) begin
      m_pc = m_pc;
    end else if (bus.halt_in) begin
      m_run = 1'b0; m_halt = 1'b1;
    end else if (bus.ret_en) begin
      if (m_stack.size() == 0) begin m_run = 1'b0; m_halt = 1'b1; m_err = 1'b1; end
      else m_pc = m_stack.pop_back();
    end else if (bus.call_en) begin
      if (m_stack.size() == DEPTH) begin m_run = 1'b0; m_halt = 1'b1; m_err = 1'b1; end
      else begin
        m_stack.push_back((m_pc + 1) % (1 << D));
        m_pc = int'(lut[bus.branch_idx]);
      end
    end else if (bus.branch_en) begin
      m_pc = int'(lut[bus.branch_idx]);
    end else begin
      m_pc = (m_pc + 1) % (1 << D);
    end
  endfunction

  task automatic clear_strobes();
    bus.start = 0; bus.stall = 0; bus.halt_in = 0;
    bus.branch_en = 0; bus.call_en = 0; bus.ret_en = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    clear_strobes();
    bus.branch_idx = 4'd0;
    Reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    n_tests++;
    if (bus.prog_ctr !== '0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%0d run=%b done=%b err=%b, required 0/0/0/0",
               bus.prog_ctr, bus.running, bus.done, bus.stack_err);
    end
    for (int i = 0; i < 16; i += 5) begin
      bus.branch_idx = 4'(i);
      #1;
      n_tests++;
      if (bus.lut_addr !== 4'(i)) begin
        n_fail++;
        $display("FAIL lut_addr_passthru: got %0d, required %0d", bus.lut_addr, i);
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    // Strobes other than start are ignored in IDLE.
    bus.branch_idx = 4'd2; bus.branch_en = 1; bus.call_en = 1; bus.ret_en = 1;
    tick();
    n_tests++;
    if (bus.prog_ctr !== '0 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores: pc=%0d run=%b, required 0/0", bus.prog_ctr, bus.running);
    end
    clear_strobes();
  endtask

  task automatic test_increment();
    bus.start = 1;
    tick();
    bus.start = 0;
    n_tests++;
    if (bus.prog_ctr !== 10'd0 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL start_run: pc=%0d run=%b, required 0/1", bus.prog_ctr, bus.running);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_tests++;
      if (bus.prog_ctr !== 10'(i) || bus.running !== 1'b1) begin
        n_fail++;
        $display("FAIL increment: pc=%0d run=%b, required %0d/1", bus.prog_ctr, bus.running, i);
      end
    end
    bus.branch_en = 1; bus.branch_idx = 4'd2;
    tick();
    bus.branch_en = 0;
    n_tests++;
    if (bus.prog_ctr !== 10'd81) begin
      n_fail++;
      $display("FAIL branch: pc=%0d, required 81", bus.prog_ctr);
    end
    tick();
    n_tests++;
    if (bus.prog_ctr !== 10'd82) begin
      n_fail++;
      $display("FAIL after_branch: pc=%0d, required 82", bus.prog_ctr);
    end
  endtask

  task automatic test_call_return();
    bus.branch_en = 1; bus.branch_idx = 4'd5;
    tick();
    bus.branch_en = 0;
    bus.call_en = 1; bus.branch_idx = 4'd13;
    tick();
    bus.call_en = 0;
    n_tests++;
    if (bus.prog_ctr !== 10'd13) begin
      n_fail++;
      $display("FAIL call_target: pc=%0d, required 13", bus.prog_ctr);
    end
    repeat (2) tick();
    n_tests++;
    if (bus.prog_ctr !== 10'd15) begin
      n_fail++;
      $display("FAIL in_subroutine: pc=%0d, required 15", bus.prog_ctr);
    end
    bus.ret_en = 1;
    tick();
    bus.ret_en = 0;
    n_tests++;
    if (bus.prog_ctr !== 10'd21 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL return: pc=%0d run=%b, required 21/1", bus.prog_ctr, bus.running);
    end
  endtask

  task automatic test_errors();
    bus.ret_en = 1;
    tick();
    bus.ret_en = 0;
    n_tests++;
    if (bus.done !== 1'b1 || bus.stack_err !== 1'b1 || bus.prog_ctr !== 10'd21 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow: done=%b err=%b pc=%0d run=%b, required 1/1/21/0",
               bus.done, bus.stack_err, bus.prog_ctr, bus.running);
    end
    bus.branch_en = 1; bus.call_en = 1;
    repeat (2) tick();
    clear_strobes();
    n_tests++;
    if (bus.prog_ctr !== 10'd21 || bus.done !== 1'b1 || bus.stack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_frozen: pc=%0d done=%b err=%b, required 21/1/1", bus.prog_ctr, bus.done, bus.stack_err);
    end
    bus.start = 1;
    tick();
    bus.start = 0;
    n_tests++;
    if (bus.prog_ctr !== 10'd0 || bus.stack_err !== 1'b0 || bus.running !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: pc=%0d err=%b run=%b done=%b, required 0/0/1/0",
               bus.prog_ctr, bus.stack_err, bus.running, bus.done);
    end
    bus.call_en = 1; bus.branch_idx = 4'd13;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      tick();
      n_tests++;
      if (bus.prog_ctr !== 10'd13 || bus.stack_err !== (i > DEPTH) || bus.done !== (i > DEPTH)) begin
        n_fail++;
        $display("FAIL call_%0d: pc=%0d err=%b done=%b, required 13/%0b/%0b",
                 i, bus.prog_ctr, bus.stack_err, bus.done, i > DEPTH, i > DEPTH);
      end
    end
    bus.call_en = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    n_tests++;
    if (bus.prog_ctr !== 10'd0 || bus.stack_err !== 1'b0 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_overflow: pc=%0d err=%b run=%b, required 0/0/1", bus.prog_ctr, bus.stack_err, bus.running);
    end
  endtask

  task automatic test_priority();
    repeat (3) tick();
    bus.stall = 1; bus.branch_en = 1; bus.branch_idx = 4'd2;
    repeat (2) tick();
    clear_strobes();
    n_tests++;
    if (bus.prog_ctr !== 10'd3 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_over_branch: pc=%0d run=%b, required 3/1", bus.prog_ctr, bus.running);
    end
    bus.start = 1;
    tick();
    bus.start = 0;
    n_tests++;
    if (bus.prog_ctr !== 10'd4) begin
      n_fail++;
      $display("FAIL start_in_run: pc=%0d, required 4", bus.prog_ctr);
    end
    bus.branch_en = 1; bus.branch_idx = 4'd7;
    tick();
    bus.branch_en = 0;
    tick();
    n_tests++;
    if (bus.prog_ctr !== 10'd0 || bus.stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%0d err=%b, required 0/0", bus.prog_ctr, bus.stack_err);
    end
    bus.call_en = 1; bus.branch_idx = 4'd13;
    tick();
    bus.halt_in = 1;
    tick();
    clear_strobes();
    n_tests++;
    if (bus.done !== 1'b1 || bus.prog_ctr !== 10'd13 || bus.stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_over_call: done=%b pc=%0d err=%b, required 1/13/0", bus.done, bus.prog_ctr, bus.stack_err);
    end
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask

  task automatic test_async_reset();
    bus.call_en = 1; bus.branch_idx = 4'd13;
    repeat (2) tick();
    bus.call_en = 0; bus.branch_en = 1; bus.branch_idx = 4'd9;
    tick();
    clear_strobes();
    n_tests++;
    if (bus.prog_ctr !== 10'd45) begin
      n_fail++;
      $display("FAIL pre_reset_pc: pc=%0d, required 45", bus.prog_ctr);
    end
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (bus.prog_ctr !== '0 || bus.running !== 1'b0 || bus.done !== 1'b0 || bus.stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%0d run=%b done=%b err=%b, required 0/0/0/0",
               bus.prog_ctr, bus.running, bus.done, bus.stack_err);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    bus.start = 1;
    tick();
    bus.start = 0;
    bus.ret_en = 1;
    tick();
    bus.ret_en = 0;
    n_tests++;
    if (bus.prog_ctr !== 10'd0 || bus.done !== 1'b1 || bus.stack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sp_cleared: pc=%0d done=%b err=%b, required 0/1/1", bus.prog_ctr, bus.done, bus.stack_err);
    end
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      bus.start      = ($urandom_range(0, 15) == 0);
      bus.stall      = ($urandom_range(0, 9) == 0);
      bus.halt_in    = ($urandom_range(0, 39) == 0);
      bus.ret_en     = ($urandom_range(0, 5) == 0);
      bus.call_en    = ($urandom_range(0, 5) == 0);
      bus.branch_en  = ($urandom_range(0, 4) == 0);
      bus.branch_idx = 4'($urandom_range(0, 15));
      tick();
      n_tests++;
      if (bus.prog_ctr !== 10'(m_pc) || bus.running !== m_run || bus.done !== m_halt || bus.stack_err !== m_err) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_c%0d: pc=%0d run=%b done=%b err=%b, required %0d/%0b/%0b/%0b",
                   c, bus.prog_ctr, bus.running, bus.done, bus.stack_err, m_pc, m_run, m_halt, m_err);
      end
    end
    clear_strobes();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) lut[i] = 10'($urandom_range(0, 1023));
    lut[2]  = 10'd81;
    lut[5]  = 10'd20;
    lut[7]  = 10'd1023;
    lut[9]  = 10'd45;
    lut[13] = 10'd13;
    test_reset();
    test_increment();
    test_call_return();
    test_errors();
    test_priority();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that owns the instruction-fetch address and drives the branch-target lookup table (4-bit index to D-bit absolute target). Each cycle it advances the PC, takes a LUT-resolved branch, calls or returns through a small return-address stack, stalls, or halts. It sits between the decoder (control strobes) and instruction memory (`prog_ctr`).

## Interface
- `D`, 10, PC and target width
- `DEPTH`, 4, return-stack entries (power of 2, ≥2)

- `Clk`  in  1  clock, rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin or restart execution at PC 0
- `stall`  in  1  hold PC and stack this cycle
- `halt_in`  in  1  decoded halt instruction
- `branch_en`  in  1  taken branch to `lut_target`
- `call_en`  in  1  push PC+1, jump to `lut_target`
- `ret_en`  in  1  pop return address into PC
- `branch_idx`  in  4  LUT index from the instruction
- `lut_addr`  out  4  index to the LUT
- `lut_target`  in  D  LUT result, combinational
- `prog_ctr`  out  D  current fetch address
- `running`  out  1  state is RUN
- `done`  out  1  state is HALT
- `stack_err`  out  1  sticky overflow/underflow flag

## Operation
- States: IDLE, RUN, HALT. Reset: IDLE, `prog_ctr`=0, stack pointer 0, `stack_err`=0, `running`=0, `done`=0.
- IDLE: PC holds 0; all strobes except `start` ignored. `start` → RUN, PC=0.
- RUN: one action per cycle. Priority: stall > halt_in > ret_en > call_en > branch_en > increment.
  - stall: PC, SP, state unchanged.
  - halt_in: → HALT; PC unchanged.
  - ret_en: SP≠0 → PC=stack[SP-1], SP-1. SP=0 (underflow) → HALT, `stack_err`=1, PC unchanged.
  - call_en: SP<DEPTH → stack[SP]=PC+1, SP+1, PC=`lut_target`. SP=DEPTH (overflow) → HALT, `stack_err`=1, PC unchanged.
  - branch_en: PC=`lut_target`.
  - none: PC=PC+1 mod 2^D (2^D-1 wraps to 0, no flag).
- HALT: PC frozen; only `start` acts: PC=0, SP=0, `stack_err`=0, → RUN.
- `start` in RUN is ignored (restart only after halt).
- `lut_addr` = `branch_idx` combinationally in every state; the LUT is read-only to this block.
- The stored return address is PC+1 mod 2^D.
- `running`/`done` decode directly from the state register.

## Timing
- All state changes occur on the rising `Clk` edge. PC update latency is one cycle: strobes sampled at edge N give the new `prog_ctr` after edge N.
- Combinational path: `branch_idx` → `lut_addr` → `lut_target` → PC D-input. It must close in one cycle with the LUT.
- Strobes are level-sampled, one instruction per cycle. A strobe held across cycles acts every cycle.
- Simultaneous strobes are resolved only by the priority order above; no error is raised.
- `stack_err` sets on the same edge as the HALT transition and clears only on `start`-from-HALT or reset.
- Reset asserted at any time (mid-call, mid-stall): state, PC, SP, and flags go to their reset values immediately, without waiting for a clock. Stack contents are don't-care after reset.
- Deassert `Reset_n` synchronously to `Clk` (handled by the system). The first edge after deassertion samples inputs normally.

## Test plan
- Reset then `start`, no strobes for 5 cycles → `prog_ctr` 0,1,2,3,4,5; `running`=1.
- In RUN at PC=7: `branch_en`=1, `branch_idx`=2 (target 81) → PC=81. Next idle cycle → 82.
- Call/return: at PC=20, `call_en`, idx=13 (target 13) → PC=13, SP=1. Two increments → 15. Then `ret_en` → PC=21, SP=0.
- Errors: `ret_en` with SP=0 → HALT, `stack_err`=1, PC frozen. Separately, DEPTH+1 consecutive calls → the 5th call halts with `stack_err`=1 and PC unchanged. Then `start` → PC=0, `stack_err`=0, RUN.
- Priority and stall: `stall`+`branch_en` together → PC held. `halt_in`+`call_en` → HALT with SP unchanged. PC at 1023 with no strobe → 0.
- Drop `Reset_n` mid-cycle with PC=45, SP=2 → outputs go to reset values before the next edge; `start` afterwards resumes from 0 with SP=0.
